// File: rtl/ps_gp_arb_pkg.sv
// Shared types and constants for the PS GP0/GP1 register-bus arbiter.
// No logic; latency and backpressure are defined by the users of this package.
package ps_gp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ISSUE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic GP0 = 1'b0;
    localparam logic GP1 = 1'b1;

endpackage

// File: rtl/ps_gp_rr_pick.sv
// Two-way round-robin pick: the port not granted last wins a tie.
// Combinational, zero latency; no backpressure (pure function of its inputs).
module ps_gp_rr_pick
    import ps_gp_arb_pkg::*;
(
    input  logic [1:0] cand,
    input  logic       last,
    output logic       gnt,
    output logic       vld
);

    always_comb begin
        vld = |cand;
        gnt = GP0;
        if (cand == 2'b11) begin
            gnt = ~last;
        end else if (cand[1]) begin
            gnt = GP1;
        end
    end

endmodule

// File: rtl/ps_gp_arbiter.sv
// Shares one req/ack register bus between the two PS AXI-Lite GP masters.
// Ready at A+1, m_req from A+2, response the cycle after m_ack; one transaction in flight, held until the master's ready.
module ps_gp_arbiter
    import ps_gp_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic [1:0]            s_awvalid,
    output logic [1:0]            s_awready,
    input  logic [2*ADDR_W-1:0]   s_awaddr,
    input  logic [1:0]            s_wvalid,
    output logic [1:0]            s_wready,
    input  logic [2*DATA_W-1:0]   s_wdata,
    input  logic [2*DATA_W/8-1:0] s_wstrb,
    output logic [1:0]            s_bvalid,
    input  logic [1:0]            s_bready,
    output logic [3:0]            s_bresp,
    input  logic [1:0]            s_arvalid,
    output logic [1:0]            s_arready,
    input  logic [2*ADDR_W-1:0]   s_araddr,
    output logic [1:0]            s_rvalid,
    input  logic [1:0]            s_rready,
    output logic [2*DATA_W-1:0]   s_rdata,
    output logic [3:0]            s_rresp,

    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic                  m_ack,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic                  m_err
);

    localparam int SW = DATA_W / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
        $error("ps_gp_arbiter: DATA_W must be 32 or 64");
    end

    state_t          state, state_d;
    logic            last_q;
    logic            port_q;
    logic [CW-1:0]   cnt;

    logic            pick_gnt;
    logic            pick_vld;
    logic [1:0]      cand;
    logic [1:0]      wr_cand;

    logic            capture;
    logic            start_issue;
    logic            finish;
    logic            timed_out;
    logic            done;

    logic              cap_wr;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [SW-1:0]     cap_wstrb;
    logic [1:0]        resp_d;
    logic [DATA_W-1:0] rdata_d;

    assign wr_cand = s_awvalid & s_wvalid;
    assign cand    = wr_cand | s_arvalid;

    ps_gp_rr_pick u_pick (
        .cand (cand),
        .last (last_q),
        .gnt  (pick_gnt),
        .vld  (pick_vld)
    );

    // Payload of the picked port; a complete write beats a read on the same port.
    always_comb begin
        cap_wr    = wr_cand[pick_gnt];
        cap_addr  = '0;
        cap_wdata = '0;
        cap_wstrb = '0;
        if (cap_wr) begin
            cap_addr  = s_awaddr[int'(pick_gnt)*ADDR_W +: ADDR_W];
            cap_wdata = s_wdata[int'(pick_gnt)*DATA_W +: DATA_W];
            cap_wstrb = s_wstrb[int'(pick_gnt)*SW +: SW];
        end else begin
            cap_addr  = s_araddr[int'(pick_gnt)*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        capture     = 1'b0;
        start_issue = 1'b0;
        finish      = 1'b0;
        timed_out   = 1'b0;
        done        = 1'b0;
        resp_d      = RESP_OKAY;
        rdata_d     = '0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    capture = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                start_issue = 1'b1;
                state_d     = ISSUE;
            end
            ISSUE: begin
                // An ack coinciding with the last allowed cycle still counts as an ack.
                if (m_ack) begin
                    finish  = 1'b1;
                    resp_d  = m_err ? RESP_SLVERR : RESP_OKAY;
                    rdata_d = m_rdata;
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                    resp_d    = RESP_SLVERR;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (m_we ? s_bready[port_q] : s_rready[port_q]) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_q    <= GP1;
            port_q    <= GP0;
            cnt       <= '0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
            s_awready <= '0;
            s_wready  <= '0;
            s_arready <= '0;
            s_bvalid  <= '0;
            s_bresp   <= '0;
            s_rvalid  <= '0;
            s_rdata   <= '0;
            s_rresp   <= '0;
        end else begin
            if (capture) begin
                port_q              <= pick_gnt;
                m_we                <= cap_wr;
                m_addr              <= cap_addr;
                m_wdata             <= cap_wdata;
                m_wstrb             <= cap_wstrb;
                s_awready[pick_gnt] <= cap_wr;
                s_wready[pick_gnt]  <= cap_wr;
                s_arready[pick_gnt] <= ~cap_wr;
            end

            if (start_issue) begin
                s_awready <= '0;
                s_wready  <= '0;
                s_arready <= '0;
                m_req     <= 1'b1;
                cnt       <= '0;
            end else if (state == ISSUE && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            if (finish) begin
                m_req <= 1'b0;
                if (m_we) begin
                    s_bvalid[port_q]               <= 1'b1;
                    s_bresp[int'(port_q)*2 +: 2]   <= resp_d;
                end else begin
                    s_rvalid[port_q]                    <= 1'b1;
                    s_rresp[int'(port_q)*2 +: 2]        <= resp_d;
                    s_rdata[int'(port_q)*DATA_W +: DATA_W] <= timed_out ? '0 : rdata_d;
                end
            end

            if (done) begin
                s_bvalid <= '0;
                s_rvalid <= '0;
                s_bresp  <= '0;
                s_rresp  <= '0;
                s_rdata  <= '0;
                last_q   <= port_q;
            end
        end
    end

endmodule

// File: tb/tb_ps_gp_arbiter.sv
// Directed bench for ps_gp_arbiter with TIMEOUT=4; expected values are hand-derived.
module tb_ps_gp_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic          aclk;
    logic          aresetn;
    logic [1:0]    s_awvalid, s_awready;
    logic [31:0]   s_awaddr;
    logic [1:0]    s_wvalid, s_wready;
    logic [63:0]   s_wdata;
    logic [7:0]    s_wstrb;
    logic [1:0]    s_bvalid, s_bready;
    logic [3:0]    s_bresp;
    logic [1:0]    s_arvalid, s_arready;
    logic [31:0]   s_araddr;
    logic [1:0]    s_rvalid, s_rready;
    logic [63:0]   s_rdata;
    logic [3:0]    s_rresp;
    logic          m_req, m_we;
    logic [15:0]   m_addr;
    logic [31:0]   m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_ack;
    logic [31:0]   m_rdata;
    logic          m_err;

    int n_cmp = 0;
    int n_err = 0;

    ps_gp_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        aresetn   = 1'b0;
        s_awvalid = '0; s_awaddr = '0; s_wvalid = '0; s_wdata = '0; s_wstrb = '0;
        s_arvalid = '0; s_araddr = '0; s_bready = '0; s_rready = '0;
        m_ack = 1'b0; m_rdata = '0; m_err = 1'b0;

        // Reset state
        step(); step();
        chk("rst_m_req", m_req, 0);
        chk("rst_ready", {s_awready, s_wready, s_arready}, 0);
        chk("rst_valid", {s_bvalid, s_rvalid}, 0);
        aresetn = 1'b1;
        step();

        // Simultaneous reads, three back-to-back: GP0, GP1, GP0
        s_araddr  = {16'h0200, 16'h0100};
        s_arvalid = 2'b11;
        s_rready  = 2'b11;
        step();
        chk("rr1_arready", s_arready, 2'b01);
        step();
        chk("rr1_m_req", m_req, 1);
        chk("rr1_m_addr", {m_we, m_addr}, {1'b0, 16'h0100});
        m_ack = 1'b1; m_rdata = 32'hA0A0_0001;
        step();
        m_ack = 1'b0;
        chk("rr1_rvalid", s_rvalid, 2'b01);
        chk("rr1_rdata", s_rdata, 64'h0000_0000_A0A0_0001);
        chk("rr1_rresp", s_rresp, 4'b0000);
        step();
        chk("rr1_done", s_rvalid, 2'b00);
        step();
        chk("rr2_arready", s_arready, 2'b10);
        step();
        chk("rr2_m_addr", m_addr, 16'h0200);
        m_ack = 1'b1; m_rdata = 32'hB0B0_0002;
        step();
        m_ack = 1'b0;
        chk("rr2_rvalid", s_rvalid, 2'b10);
        chk("rr2_rdata", s_rdata, 64'hB0B0_0002_0000_0000);
        step();
        step();
        chk("rr3_arready", s_arready, 2'b01);
        s_arvalid = 2'b00;
        step();
        m_ack = 1'b1; m_rdata = 32'hC0C0_0003;
        step();
        m_ack = 1'b0;
        chk("rr3_rdata", s_rdata, 64'h0000_0000_C0C0_0003);
        step();

        // GP0 write, ack on the 4th m_req cycle (coincides with the timeout cycle)
        s_awaddr = {16'h0000, 16'h0010};
        s_wdata  = {32'h0, 32'hDEAD_BEEF};
        s_wstrb  = 8'h0F;
        s_awvalid = 2'b01; s_wvalid = 2'b01;
        s_bready  = 2'b11;
        step();
        chk("wr0_awready", {s_awready, s_wready, s_arready}, 6'b01_01_00);
        chk("wr0_m_req_grant", m_req, 0);
        s_awvalid = 2'b00; s_wvalid = 2'b00;
        step();
        chk("wr0_ready_clr", {s_awready, s_wready}, 4'b0000);
        chk("wr0_bus", {m_req, m_we, m_addr, m_wdata, m_wstrb},
            {1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF});
        step(); step(); step();
        chk("wr0_m_req_held", m_req, 1);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        chk("wr0_bvalid", s_bvalid, 2'b01);
        chk("wr0_bresp", s_bresp, 4'b0000);
        chk("wr0_m_req_drop", m_req, 0);
        step();
        chk("wr0_done", s_bvalid, 2'b00);

        // GP1 aw+w+ar with GP0 ar pending: GP1 write, then GP0 read, then GP1 read
        s_awaddr  = {16'h0030, 16'h0000};
        s_wdata   = {32'h1234_5678, 32'h0};
        s_wstrb   = 8'h30;
        s_araddr  = {16'h0240, 16'h0140};
        s_awvalid = 2'b10; s_wvalid = 2'b10; s_arvalid = 2'b11;
        step();
        chk("mix_w_grant", {s_awready, s_wready, s_arready}, 6'b10_10_00);
        s_awvalid = 2'b00; s_wvalid = 2'b00;
        step();
        chk("mix_w_bus", {m_we, m_addr, m_wdata, m_wstrb}, {1'b1, 16'h0030, 32'h1234_5678, 4'h3});
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        chk("mix_w_bvalid", s_bvalid, 2'b10);
        step();
        step();
        chk("mix_r0_grant", s_arready, 2'b01);
        s_arvalid = 2'b10;
        step();
        chk("mix_r0_addr", {m_we, m_addr}, {1'b0, 16'h0140});
        m_ack = 1'b1; m_rdata = 32'h1111_2222;
        step();
        m_ack = 1'b0;
        chk("mix_r0_rdata", {s_rvalid, s_rdata}, {2'b01, 64'h0000_0000_1111_2222});
        step();
        step();
        chk("mix_r1_grant", s_arready, 2'b10);
        s_arvalid = 2'b00;
        step();
        chk("mix_r1_addr", m_addr, 16'h0240);
        m_ack = 1'b1; m_rdata = 32'h3333_4444;
        step();
        m_ack = 1'b0;
        chk("mix_r1_rdata", {s_rvalid, s_rdata}, {2'b10, 64'h3333_4444_0000_0000});
        step();

        // GP1 write answered with m_err
        s_awaddr  = {16'h0044, 16'h0000};
        s_awvalid = 2'b10; s_wvalid = 2'b10;
        step();
        chk("err_grant", {s_awready, s_wready}, 4'b1010);
        s_awvalid = 2'b00; s_wvalid = 2'b00;
        step();
        m_ack = 1'b1; m_err = 1'b1;
        step();
        m_ack = 1'b0; m_err = 1'b0;
        chk("err_bresp", {s_bvalid, s_bresp}, {2'b10, 4'b1000});
        step();
        chk("err_done", {s_bvalid, s_bresp}, 6'b0);
        step();
        chk("err_idle", {m_req, s_awready, s_wready, s_arready}, 7'b0);

        // GP0 read with no ack: m_req high for exactly TIMEOUT cycles
        s_rready  = 2'b00;
        s_arvalid = 2'b01;
        step();
        s_arvalid = 2'b00;
        step();
        chk("to_req_c1", m_req, 1);
        step();
        step();
        step();
        chk("to_req_c4", m_req, 1);
        step();
        chk("to_req_drop", m_req, 0);
        chk("to_rresp", {s_rvalid, s_rresp, s_rdata}, {2'b01, 4'b0010, 64'h0});
        m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
        step();
        m_ack = 1'b0;
        chk("to_late_ack", {m_req, s_rvalid, s_rdata}, {1'b0, 2'b01, 64'h0});
        s_rready = 2'b11;
        step();
        chk("to_done", s_rvalid, 2'b00);
        step();
        chk("to_no_reissue", m_req, 0);

        // Reset during ISSUE, then a tie must go to GP0 again
        s_arvalid = 2'b10;
        step();
        s_arvalid = 2'b00;
        step();
        chk("arst_pre_req", m_req, 1);
        aresetn = 1'b0;
        #1;
        chk("arst_req", m_req, 0);
        chk("arst_vr", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}, 10'b0);
        step();
        aresetn   = 1'b1;
        s_arvalid = 2'b11;
        step();
        chk("arst_tie_gp0", s_arready, 2'b01);
        s_arvalid = 2'b00;
        step();
        m_ack = 1'b1; m_rdata = 32'h5555_AAAA;
        step();
        m_ack = 1'b0;
        chk("arst_rdata", {s_rvalid, s_rdata}, {2'b01, 64'h0000_0000_5555_AAAA});
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
